// File: rtl/wrapping_counter.sv
// Modulo-RANGE up-counter used as a FIFO read or write pointer.
// Latency: count updates on the rising clock edge after clear/increment.
// Backpressure: none; the caller gates increment.
module wrapping_counter #(
  parameter int RANGE = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     increment,
  output logic [$clog2(RANGE)-1:0] count
);

  localparam int CW = $clog2(RANGE);
  localparam logic [CW-1:0] LAST = CW'(RANGE - 1);

  // Clear wins over increment; wrap from RANGE-1 back to 0 for any RANGE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/advanced_fifo.sv
// Synchronous first-word fall-through FIFO with flush, watermarks and error pulses.
// Latency: a written word is visible on read_data one cycle after the write edge.
// Backpressure: writes while full are dropped (write_miss), reads while empty are ignored (read_error).
module advanced_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         write_enable,
  input  logic [WIDTH-1:0]             write_data,
  output logic                         write_miss,
  output logic                         full,
  input  logic                         read_enable,
  output logic [WIDTH-1:0]             read_data,
  output logic                         read_error,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic [$clog2(DEPTH+1)-1:0]   lower_threshold,
  input  logic [$clog2(DEPTH+1)-1:0]   upper_threshold,
  output logic                         lower_threshold_status,
  output logic                         upper_threshold_status
);

  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 wr_accept;
  logic                 rd_accept;

  // Status flags depend only on the registered level, never on inputs.
  assign full  = (level == LEVEL_MAX);
  assign empty = (level == '0);

  // Flush overrides both ports; a read in the same cycle never makes room for a write.
  assign wr_accept = write_enable && !full  && !flush;
  assign rd_accept = read_enable  && !empty && !flush;

  assign read_data = mem[rd_ptr];

  assign lower_threshold_status = (level <= lower_threshold);
  assign upper_threshold_status = (level >= upper_threshold);

  wrapping_counter #(.RANGE(DEPTH)) u_wr_ptr (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (flush),
    .increment (wr_accept),
    .count     (wr_ptr)
  );

  wrapping_counter #(.RANGE(DEPTH)) u_rd_ptr (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (flush),
    .increment (rd_accept),
    .count     (rd_ptr)
  );

  // Storage is deliberately not reset; level alone marks which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr] <= write_data;
    end
  end

  // Occupancy tracks accepted pushes and pops; flush empties immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else if (wr_accept && !rd_accept) begin
      level <= level + 1'b1;
    end else if (rd_accept && !wr_accept) begin
      level <= level - 1'b1;
    end
  end

  // One-cycle pulses reporting a dropped write or an empty read from the previous cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_miss <= 1'b0;
      read_error <= 1'b0;
    end else begin
      write_miss <= write_enable && full  && !flush;
      read_error <= read_enable  && empty && !flush;
    end
  end

endmodule

// File: doc/advanced_fifo.md
ADVANCED_FIFO -- requirements
Module: advanced_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of entries (any integer >=2; not restricted to powers of two).
REQ-003 SHALL derive local LEVEL_WIDTH = $clog2(DEPTH+1).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  synchronous empty request.
REQ-007 SHALL have port write_enable  input  1  write request.
REQ-008 SHALL have port write_data  input  WIDTH  data to write.
REQ-009 SHALL have port write_miss  output  1  one-cycle pulse: the previous-cycle write was dropped.
REQ-010 SHALL have port full  output  1  level equals DEPTH.
REQ-011 SHALL have port read_enable  input  1  read request (pops head).
REQ-012 SHALL have port read_data  output  WIDTH  current head entry (first-word fall-through).
REQ-013 SHALL have port read_error  output  1  one-cycle pulse: the previous-cycle read hit an empty FIFO.
REQ-014 SHALL have port empty  output  1  level equals 0.
REQ-015 SHALL have port level  output  LEVEL_WIDTH  number of stored entries.
REQ-016 SHALL have ports lower_threshold and upper_threshold  input  LEVEL_WIDTH  quasi-static watermarks.
REQ-017 SHALL have ports lower_threshold_status and upper_threshold_status  output  1  watermark flags.

Function
REQ-018 Write SHALL be accepted at a rising edge iff write_enable=1, full=0 and flush=0.
REQ-019 Write with full=1 and flush=0 SHALL drop data, leave state unchanged, and assert write_miss the next cycle only; a concurrent read does not free room for it.
REQ-020 Read SHALL be accepted iff read_enable=1, empty=0 and flush=0; read_data SHALL show the head combinationally, with zero latency.
REQ-021 Read with empty=1 and flush=0 SHALL leave state unchanged and assert read_error the next cycle only.
REQ-022 Simultaneous accepted read and write SHALL keep level unchanged, and full/empty unchanged.
REQ-023 A write into an empty FIFO SHALL appear on read_data and deassert empty one cycle after the write edge.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 flush=1 SHALL have priority over reads and writes: it zeroes pointers and level at the edge, and generates no write_miss or read_error.
REQ-026 full, empty and level SHALL come from registered state only, with no combinational path from inputs.
REQ-027 lower_threshold_status SHALL equal (level <= lower_threshold); upper_threshold_status SHALL equal (level >= upper_threshold).
REQ-028 read_data SHALL be don't-care while empty=1.

Reset
REQ-029 On resetn=0, outputs SHALL take: empty=1, full=0, level=0, write_miss=0, read_error=0, and pointers=0 immediately; storage contents are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first write after release SHALL be read first.

Structure
REQ-031 No shared package SHALL be required; LEVEL_WIDTH is a local constant.
REQ-032 Pointers SHALL be two instances of sub-module wrapping_counter (parameter RANGE=DEPTH; ports clock, resetn, clear, increment, count).
REQ-033 Storage SHALL be a flop array of DEPTH x WIDTH.

Verification (DEPTH=5, WIDTH=8)
REQ-034 Write 0x11..0x55 to full -> level 1,2,3,4,5; full=1 after the 5th write; upper_threshold_status=1 at level>=4 with upper_threshold=4.
REQ-035 Sixth write 0xAA while full -> write_miss pulses one cycle; level stays 5; reads return 0x11..0x55 in order, then empty=1.
REQ-036 Read while empty -> read_error pulses one cycle; level=0; no data change.
REQ-037 Continuous write+read for 100 cycles with incrementing data -> read_data matches each written value; pointers wrap 20 times; level stays at 1; full and empty stay 0 after the first cycle.
REQ-038 Three writes, then flush together with write_enable=1 and read_enable=1 -> next cycle level=0, empty=1, no pulses; lower_threshold_status=1 with lower_threshold=1.
REQ-039 resetn pulsed low with 3 entries stored -> empty=1 and level=0 asynchronously; subsequent write 0x7E reads back 0x7E.
